// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - memop encodings, bridge FSM states and error readback word
package dmem_pkg;

    localparam logic [1:0]  MEMOP_W          = 2'b00;
    localparam logic [1:0]  MEMOP_H          = 2'b01;
    localparam logic [1:0]  MEMOP_B          = 2'b10;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and lane extraction/extension for loads
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  memop_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Reserved memop 2'b11 falls through to the word case.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (memop_i)
            MEMOP_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            MEMOP_H: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = unsigned_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// rtl/dmem_bus_bridge.sv - core data-memory port to registered valid/ready bus; MISALIGN_TRAP_EN traps misaligned half/word
module dmem_bus_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_memread,
    input  logic        cpu_memwrite,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_memop,
    input  logic        cpu_unsigned,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
    logic [1:0]  lo_q, lo_d, memop_q, memop_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d, uns_q, uns_d, err_q, err_d;

    logic        cpu_req, in_idle, timeout_hit;
    logic [1:0]  al_memop, al_lo;
    logic        al_uns;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;

    assign cpu_req     = cpu_memread | cpu_memwrite;
    assign in_idle     = (state_q == IDLE);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= TIMEOUT - 32'd1);

    // Steering works on the live request while latching, then on the latched copy.
    assign al_memop = in_idle ? cpu_memop     : memop_q;
    assign al_lo    = in_idle ? cpu_addr[1:0] : lo_q;
    assign al_uns   = in_idle ? cpu_unsigned  : uns_q;

    dmem_lane_align u_align (
        .memop_i    (al_memop),
        .addr_lo_i  (al_lo),
        .unsigned_i (al_uns),
        .wdata_i    (cpu_wdata),
        .rdata_i    (bus_rdata),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (cpu_memop == MEMOP_H) ? cpu_addr[0]
                      : ((cpu_memop != MEMOP_B) && (cpu_addr[1:0] != 2'b00));
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        memop_d = memop_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = {cpu_addr[31:2], 2'b00};
                    lo_d    = cpu_addr[1:0];
                    we_d    = cpu_memwrite;
                    be_d    = al_be;
                    wdata_d = al_wdata;
                    memop_d = cpu_memop;
                    uns_d   = cpu_unsigned;
                    cnt_d   = 32'd0;
                    state_d = REQ;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                    end
`endif
                end
            end
            REQ: begin
                cnt_d = cnt_q + 32'd1;
                if (bus_ready) begin
                    state_d = we_q ? DONE : RESP;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                end
            end
            RESP: begin
                cnt_d = cnt_q + 32'd1;
                if (bus_rvalid) begin
                    state_d = DONE;
                    rdata_d = al_rdata;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            lo_q    <= 2'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            memop_q <= MEMOP_W;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
            cnt_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            memop_q <= memop_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign cpu_stall = cpu_req & (state_q != DONE);
    assign cpu_rdata = rdata_q;
    assign cpu_err   = err_q;
    assign bus_valid = (state_q == REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb/tb_dmem_bus_bridge.sv - table-driven bench for dmem_bus_bridge built with TIMEOUT=8
module tb_dmem_bus_bridge;
    import dmem_pkg::*;

    logic        clk, rst;
    logic        cpu_memread, cpu_memwrite, cpu_unsigned;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_memop;
    logic        cpu_stall, cpu_err;
    logic [31:0] cpu_rdata;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_bus_bridge #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_memop(cpu_memop), .cpu_unsigned(cpu_unsigned),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd, wr;
        logic [1:0]  op;
        logic        uns;
        logic [31:0] addr, wdata;
        logic        ready;
        int          rdelay;
        logic [31:0] brdata;
        logic        exp_bus;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        logic        exp_we;
        int          exp_stall;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int stalls = 0;
        int wait_n = 0;
        bit done = 0;
        bit seen = 0;
        bit pend = 0;
        @(negedge clk);
        cpu_memread = v.rd; cpu_memwrite = v.wr; cpu_memop = v.op; cpu_unsigned = v.uns;
        cpu_addr = v.addr; cpu_wdata = v.wdata;
        bus_ready = v.ready; bus_rdata = v.brdata; bus_rvalid = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (bus_valid && !seen) begin
                seen = 1;
                chk({v.name, " bus_addr"},  bus_addr,  v.exp_baddr);
                chk({v.name, " bus_be"},    {28'd0, bus_be}, {28'd0, v.exp_be});
                chk({v.name, " bus_wdata"}, bus_wdata, v.exp_bwdata);
                chk({v.name, " bus_we"},    {31'd0, bus_we}, {31'd0, v.exp_we});
            end
            if (bus_valid && bus_ready && !v.wr && !pend) begin
                pend   = 1;
                wait_n = v.rdelay;
            end
            if (cpu_stall) begin
                stalls++;
            end else begin
                done = 1;
                chk({v.name, " stall_cycles"}, stalls, v.exp_stall);
                chk({v.name, " cpu_err"},   {31'd0, cpu_err},   {31'd0, v.exp_err});
                chk({v.name, " bus_txn"},   {31'd0, seen},      {31'd0, v.exp_bus});
                chk({v.name, " done_valid"}, {31'd0, bus_valid}, 32'd0);
                if (v.chk_rd) chk({v.name, " cpu_rdata"}, cpu_rdata, v.exp_rdata);
                cpu_memread = 1'b0; cpu_memwrite = 1'b0; bus_rvalid = 1'b0; bus_ready = 1'b0;
            end
            if (!done) begin
                @(negedge clk);
                if (pend) begin
                    bus_rvalid = (wait_n == 0);
                    wait_n--;
                end
            end
        end
        if (!done) begin
            chk({v.name, " completion"}, 32'd0, 32'd1);
            cpu_memread = 1'b0; cpu_memwrite = 1'b0; bus_rvalid = 1'b0; bus_ready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           name   rd wr op       uns addr      wdata         rdy dly   brdata        bus baddr     be     bwdata        we stl err chk rdata
        vecs[0]  = '{"sw",   0, 1, MEMOP_W, 0, 32'h10, 32'h11223344, 1, 0,    32'h0,        1, 32'h10, 4'hF, 32'h11223344, 1, 2, 0, 0, 32'h0};
        vecs[1]  = '{"sb",   0, 1, MEMOP_B, 0, 32'h13, 32'h000000AB, 1, 0,    32'h0,        1, 32'h10, 4'h8, 32'hABABABAB, 1, 2, 0, 0, 32'h0};
        vecs[2]  = '{"sh_hi",0, 1, MEMOP_H, 0, 32'h12, 32'hDEAD1234, 1, 0,    32'h0,        1, 32'h10, 4'hC, 32'h12341234, 1, 2, 0, 0, 32'h0};
        vecs[3]  = '{"sh_lo",0, 1, MEMOP_H, 0, 32'h10, 32'h00005678, 1, 0,    32'h0,        1, 32'h10, 4'h3, 32'h56785678, 1, 2, 0, 0, 32'h0};
        vecs[4]  = '{"sb0",  0, 1, MEMOP_B, 0, 32'h20, 32'h000000CD, 1, 0,    32'h0,        1, 32'h20, 4'h1, 32'hCDCDCDCD, 1, 2, 0, 0, 32'h0};
        vecs[5]  = '{"rw",   1, 1, MEMOP_W, 0, 32'h44, 32'hA1B2C3D4, 1, 0,    32'h0,        1, 32'h44, 4'hF, 32'hA1B2C3D4, 1, 2, 0, 0, 32'h0};
        vecs[6]  = '{"lb",   1, 0, MEMOP_B, 0, 32'h21, 32'h0,        1, 4,    32'h00008000, 1, 32'h20, 4'h2, 32'h0,        0, 7, 0, 1, 32'hFFFFFF80};
        vecs[7]  = '{"lbu",  1, 0, MEMOP_B, 1, 32'h21, 32'h0,        1, 0,    32'h00008000, 1, 32'h20, 4'h2, 32'h0,        0, 3, 0, 1, 32'h00000080};
        vecs[8]  = '{"lh",   1, 0, MEMOP_H, 0, 32'h22, 32'h0,        1, 0,    32'h80017FFF, 1, 32'h20, 4'hC, 32'h0,        0, 3, 0, 1, 32'hFFFF8001};
        vecs[9]  = '{"lhu",  1, 0, MEMOP_H, 1, 32'h22, 32'h0,        1, 0,    32'h80017FFF, 1, 32'h20, 4'hC, 32'h0,        0, 3, 0, 1, 32'h00008001};
        vecs[10] = '{"lw",   1, 0, MEMOP_W, 0, 32'h30, 32'h0,        1, 1,    32'hCAFEF00D, 1, 32'h30, 4'hF, 32'h0,        0, 4, 0, 1, 32'hCAFEF00D};
`ifdef MISALIGN_TRAP_EN
        vecs[11] = '{"lw_mis",1,0, MEMOP_W, 0, 32'h22, 32'h0,        1, 0,    32'h12345678, 0, 32'h20, 4'hF, 32'h0,        0, 1, 1, 1, 32'hDEADBEEF};
`else
        vecs[11] = '{"lw_mis",1,0, MEMOP_W, 0, 32'h22, 32'h0,        1, 0,    32'h12345678, 1, 32'h20, 4'hF, 32'h0,        0, 3, 0, 1, 32'h12345678};
`endif
        vecs[12] = '{"lrsv", 1, 0, 2'b11,   0, 32'h40, 32'h0,        1, 0,    32'hA5A50001, 1, 32'h40, 4'hF, 32'h0,        0, 3, 0, 1, 32'hA5A50001};
        vecs[13] = '{"lh_lo",1, 0, MEMOP_H, 0, 32'h10, 32'h0,        1, 2,    32'h1234F00D, 1, 32'h10, 4'h3, 32'h0,        0, 5, 0, 1, 32'hFFFFF00D};
        vecs[14] = '{"lb3",  1, 0, MEMOP_B, 0, 32'h13, 32'h0,        1, 0,    32'h7F000000, 1, 32'h10, 4'h8, 32'h0,        0, 3, 0, 1, 32'h0000007F};
        vecs[15] = '{"to_req",1,0, MEMOP_W, 0, 32'h50, 32'h0,        0, 0,    32'h0,        1, 32'h50, 4'hF, 32'h0,        0, 9, 1, 1, 32'hDEADBEEF};
        vecs[16] = '{"to_rsp",1,0, MEMOP_W, 0, 32'h54, 32'h0,        1, 1000, 32'h0,        1, 32'h54, 4'hF, 32'h0,        0, 9, 1, 1, 32'hDEADBEEF};
        vecs[17] = '{"to_st",0, 1, MEMOP_W, 0, 32'h58, 32'h01020304, 0, 0,    32'h0,        1, 32'h58, 4'hF, 32'h01020304, 1, 9, 1, 1, 32'hDEADBEEF};

        rst = 1'b0;
        cpu_memread = 0; cpu_memwrite = 0; cpu_unsigned = 0; cpu_memop = MEMOP_W;
        cpu_addr = 0; cpu_wdata = 0; bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("reset bus_addr",  bus_addr,  32'd0);
        chk("reset cpu_rdata", cpu_rdata, 32'd0);
        chk("reset misc", {25'd0, bus_we, bus_be, cpu_err, cpu_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) run_vec(vecs[i]);

        // Error pulse must last exactly the DONE cycle; readback holds.
        run_vec(vecs[15]);
        @(negedge clk); #1;
        chk("err_pulse_width", {31'd0, cpu_err}, 32'd0);
        chk("err_rdata_hold",  cpu_rdata, 32'hDEADBEEF);

        // Core inputs changing mid-access must not disturb the latched payload.
        @(negedge clk);
        cpu_memwrite = 1; cpu_memop = MEMOP_W; cpu_addr = 32'h60; cpu_wdata = 32'h01020304; bus_ready = 0;
        repeat (2) @(negedge clk);
        cpu_addr = 32'h70; cpu_wdata = 32'hFFFFFFFF; cpu_memop = MEMOP_B;
        #1;
        chk("hold bus_addr",  bus_addr,  32'h60);
        chk("hold bus_wdata", bus_wdata, 32'h01020304);
        chk("hold bus_be",    {28'd0, bus_be}, 32'hF);
        bus_ready = 1;
        @(negedge clk); #1;
        chk("hold done_stall", {31'd0, cpu_stall}, 32'd0);
        cpu_memwrite = 0; bus_ready = 0;

        // Async reset while waiting in RESP drops the transaction immediately.
        @(negedge clk);
        cpu_memread = 1; cpu_memop = MEMOP_W; cpu_addr = 32'h80; cpu_wdata = 0; bus_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_resp pre_stall", {31'd0, cpu_stall}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_resp bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_resp bus_addr",  bus_addr,  32'd0);
        chk("rst_resp cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_resp misc", {25'd0, bus_we, bus_be, cpu_err, 1'b0}, 32'd0);
        cpu_memread = 0; bus_ready = 0;
        @(negedge clk);
        rst = 1'b1;
        run_vec('{"lw_after_rst", 1, 0, MEMOP_W, 0, 32'h84, 32'h0, 1, 0, 32'h5A5A1234,
                  1, 32'h84, 4'hF, 32'h0, 0, 3, 0, 1, 32'h5A5A1234});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
